// File: rtl/bin2csd_core.sv
// Binary to canonical-signed-digit converter: LSB-first carry scan, registered result, 1-cycle latency.
// Define BIN2CSD_CARRY_OUT_EN to add the registered carry-out port co.
module bin2csd_core #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           arst_n,
  input  logic [W-1:0]   x,
`ifdef BIN2CSD_CARRY_OUT_EN
  output logic           co,
`endif
  output logic [2*W-1:0] y
);

  // Digit codes: 00 = 0, 01 = +1, 11 = -1.
  localparam logic [1:0] DIG_ZERO = 2'b00;
  localparam logic [1:0] DIG_POS  = 2'b01;
  localparam logic [1:0] DIG_NEG  = 2'b11;

  logic [W:0]     x_ext;
  logic [W:0]     B;
  logic [2*W-1:0] y_d;
  logic [2*W-1:0] y_q;

  assign x_ext = {1'b0, x};

  always_comb begin
    logic carry;
    carry = 1'b0;
    B     = '0;
    y_d   = '0;
    for (int i = 0; i < W; i++) begin
      B[i] = carry;
      // A bit equal to the incoming carry cancels; otherwise look ahead to start or end a run of ones.
      if (x_ext[i] == carry) begin
        y_d[2*i +: 2] = DIG_ZERO;
      end else if (x_ext[i+1]) begin
        y_d[2*i +: 2] = DIG_NEG;
        carry         = 1'b1;
      end else begin
        y_d[2*i +: 2] = DIG_POS;
        carry         = 1'b0;
      end
    end
    B[W] = carry;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      y_q <= '0;
    end else begin
      y_q <= y_d;
    end
  end

  assign y = y_q;

`ifdef BIN2CSD_CARRY_OUT_EN
  logic co_d;
  logic co_q;

  assign co_d = B[W];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      co_q <= 1'b0;
    end else begin
      co_q <= co_d;
    end
  end

  assign co = co_q;
`endif

endmodule

// File: tb/tb_bin2csd_core.sv
// Directed and exhaustive bench for bin2csd_core (W=4); builds with or without BIN2CSD_CARRY_OUT_EN.
module tb_bin2csd_core;

  localparam int W = 4;

  logic           clk;
  logic           arst_n;
  logic [W-1:0]   x;
  logic [2*W-1:0] y;
`ifdef BIN2CSD_CARRY_OUT_EN
  logic           co;
`endif

  int checks   = 0;
  int failures = 0;

  logic [W-1:0]   dir_x [8];
  logic [2*W-1:0] dir_y [8];

  bin2csd_core #(.W(W)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .x      (x),
`ifdef BIN2CSD_CARRY_OUT_EN
    .co     (co),
`endif
    .y      (y)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver: present v away from the edge, then sample just after the next rising edge.
  task automatic step(input logic [W-1:0] v);
    @(negedge clk);
    x = v;
    @(posedge clk);
    #1;
  endtask

  // Weighted digit sum of a CSD word (illegal code 10 counted as 0 here, flagged separately).
  function automatic int csd_sum(input logic [2*W-1:0] w);
    int s;
    s = 0;
    for (int i = 0; i < W; i++) begin
      if (w[2*i +: 2] == 2'b01) s += (1 << i);
      else if (w[2*i +: 2] == 2'b11) s -= (1 << i);
    end
    return s;
  endfunction

  function automatic int mod_w(input int s);
    return ((s % (1 << W)) + (1 << W)) % (1 << W);
  endfunction

  function automatic logic has_code10(input logic [2*W-1:0] w);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < W; i++) if (w[2*i +: 2] == 2'b10) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic has_adjacent(input logic [2*W-1:0] w);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < W - 1; i++)
      if (w[2*i +: 2] != 2'b00 && w[2*(i+1) +: 2] != 2'b00) bad = 1'b1;
    return bad;
  endfunction

  initial begin
    logic [W-1:0] last_x;

    dir_x[0] = 4'b0000; dir_y[0] = 8'b00000000;
    dir_x[1] = 4'b0001; dir_y[1] = 8'b00000001;
    dir_x[2] = 4'b0010; dir_y[2] = 8'b00000100;
    dir_x[3] = 4'b0100; dir_y[3] = 8'b00010000;
    dir_x[4] = 4'b1000; dir_y[4] = 8'b01000000;
    dir_x[5] = 4'b0110; dir_y[5] = 8'b01001100;
    dir_x[6] = 4'b0111; dir_y[6] = 8'b01000011;
    dir_x[7] = 4'b1111; dir_y[7] = 8'b00000011;

    // Reset asserted before any clock edge: output clears immediately.
    x      = 4'b0111;
    arst_n = 1'b1;
    #1 arst_n = 1'b0;
    #1;
    check("rst_no_edge_y", 64'(y), 64'h0);
`ifdef BIN2CSD_CARRY_OUT_EN
    check("rst_no_edge_co", 64'(co), 64'h0);
`endif
    @(posedge clk);
    #1;
    check("rst_held_y", 64'(y), 64'h0);

    // First edge after release loads the current x.
    @(negedge clk);
    x      = 4'b0001;
    arst_n = 1'b1;
    #1;
    check("rel_pre_edge_y", 64'(y), 64'h0);
    @(posedge clk);
    #1;
    check("rel_first_y", 64'(y), 64'h01);

    // Directed vectors
    for (int k = 0; k < 8; k++) begin
      step(dir_x[k]);
      check($sformatf("dir_x%b", dir_x[k]), 64'(y), 64'(dir_y[k]));
    end
`ifdef BIN2CSD_CARRY_OUT_EN
    check("wrap_co", 64'(co), 64'h1);
    step(4'b0110);
    check("co_0110", 64'(co), 64'h0);
`endif

    // Exhaustive sweep with back-to-back inputs and latency check.
    last_x = x;
    for (int v = 0; v < (1 << W); v++) begin
      @(negedge clk);
      x = v[W-1:0];
      #1;
      check($sformatf("lat_hold_%0d", v), 64'(mod_w(csd_sum(y))), 64'(last_x));
      @(posedge clk);
      #1;
      check($sformatf("sum_%0d", v), 64'(mod_w(csd_sum(y))), 64'(v));
      check($sformatf("code10_%0d", v), 64'(has_code10(y)), 64'h0);
      check($sformatf("adj_%0d", v), 64'(has_adjacent(y)), 64'h0);
`ifdef BIN2CSD_CARRY_OUT_EN
      check($sformatf("full_%0d", v), 64'(csd_sum(y) + (co ? (1 << W) : 0)), 64'(v));
`endif
      last_x = v[W-1:0];
    end

    // Reset in the middle of a changing stream.
    step(4'b0011);
    step(4'b1001);
    @(negedge clk);
    x = 4'b0101;
    #2 arst_n = 1'b0;
    #1;
    check("mid_rst_y", 64'(y), 64'h0);
`ifdef BIN2CSD_CARRY_OUT_EN
    check("mid_rst_co", 64'(co), 64'h0);
`endif
    @(posedge clk);
    #1;
    x = 4'b1010;
    check("mid_rst_hold_y", 64'(y), 64'h0);
    @(negedge clk);
    x      = 4'b0110;
    arst_n = 1'b1;
    #1;
    check("mid_rel_no_stale_y", 64'(y), 64'h0);
    @(posedge clk);
    #1;
    check("mid_rel_first_y", 64'(y), 64'h4C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Time bound so the run always terminates.
  initial begin
    #100000;
    failures++;
    $display("FAIL timeout: got running expected finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
